// File: rtl/bcd_time_loader_pkg.sv
// Shared definitions for the BCD time loader: digit positions, FSM states,
// and the binary field widths of the clock counter's parallel-load port.
package bcd_time_loader_pkg;

  // Digit positions in entry order; matches the display mux seg_select order.
  localparam logic [2:0] DIG_HR_MSD  = 3'd0;
  localparam logic [2:0] DIG_HR_LSD  = 3'd1;
  localparam logic [2:0] DIG_MIN_MSD = 3'd2;
  localparam logic [2:0] DIG_MIN_LSD = 3'd3;
  localparam logic [2:0] DIG_SEC_MSD = 3'd4;
  localparam logic [2:0] DIG_SEC_LSD = 3'd5;

  // Binary widths of the loaded time fields.
  localparam int HOUR_W   = 5;
  localparam int MINSEC_W = 6;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOAD    = 2'd1,
    ERROR   = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_to_binary.sv
// Combinational two-digit BCD to binary converter with a range flag.
// Inverse of binary_to_bcd. The MSD is scaled by 10 with shifts and an add
// (x*8 + x*2), so no multiplier is needed. The flag is raised when either
// digit is not a decimal digit, or when the result reaches the exclusive limit.
// If the LSD is tied to 0, the same check rejects an MSD whose tens value is
// already too large.
module bcd_to_binary (
  input  logic [3:0] msd,
  input  logic [3:0] lsd,
  input  logic [6:0] limit,
  output logic [6:0] value,
  output logic       out_of_range
);

  // The sum is 8 bits wide so that an illegal 15*10+15 cannot wrap into range.
  logic [7:0] sum;

  assign sum          = ({4'd0, msd} << 3) + ({4'd0, msd} << 1) + {4'd0, lsd};
  assign value        = sum[6:0];
  assign out_of_range = (msd > 4'd9) || (lsd > 4'd9) || (sum >= {1'b0, limit});

endmodule

// File: rtl/bcd_time_loader.sv
// Collects six BCD digits (hours MSD .. seconds LSD), range-checks each one
// on arrival, and presents binary hours/minutes/seconds with a load strobe.
// A bad digit aborts the entry and raises a one-cycle error strobe.
module bcd_time_loader
  import bcd_time_loader_pkg::*;
#(
  parameter int HOUR_LIMIT    = 24,
  parameter int MIN_SEC_LIMIT = 60
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [3:0]          i_bcd,
  input  logic                i_bcd_valid,
  output logic                o_bcd_ready,
  input  logic                i_abort,
  output logic [2:0]          o_digit_idx,
  output logic [HOUR_W-1:0]   o_hours,
  output logic [MINSEC_W-1:0] o_minutes,
  output logic [MINSEC_W-1:0] o_seconds,
  output logic                o_load,
  output logic                o_error
);

  state_t state, state_next;

  logic [2:0]          idx;
  logic [3:0]          msd_hold;
  logic [HOUR_W-1:0]   stage_hr;
  logic [MINSEC_W-1:0] stage_min;
  logic [MINSEC_W-1:0] stage_sec;

  logic       is_lsd;
  logic       accept;
  logic [3:0] conv_msd;
  logic [3:0] conv_lsd;
  logic [6:0] conv_limit;
  logic [6:0] conv_value;
  logic       digit_bad;
  logic       conv_value_unused;

  // Odd positions are LSDs. They are checked against the MSD already held.
  // Even positions are MSDs. They are checked as MSD*10 with an LSD of 0.
  assign is_lsd     = idx[0];
  assign conv_msd   = is_lsd ? msd_hold : i_bcd;
  assign conv_lsd   = is_lsd ? i_bcd : 4'd0;
  assign conv_limit = (idx <= DIG_HR_LSD) ? 7'(HOUR_LIMIT) : 7'(MIN_SEC_LIMIT);

  bcd_to_binary u_bcd_to_binary (
    .msd          (conv_msd),
    .lsd          (conv_lsd),
    .limit        (conv_limit),
    .value        (conv_value),
    .out_of_range (digit_bad)
  );

  // The widest field is 6 bits, so the converter's top bit is never loaded.
  // It can only be set for values that are already flagged as out of range.
  assign conv_value_unused = conv_value[6];

  // An abort takes priority over a digit presented in the same cycle.
  assign accept = (state == COLLECT) && i_bcd_valid && !i_abort;

  // State register.
  // NOTE: sequential state uses non-blocking assignments. Every flop then
  // samples the values from before the edge, whatever order the blocks run in.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= COLLECT;
    else         state <= state_next;
  end

  // Next-state logic. LOAD and ERROR each last one cycle.
  // NOTE: the default is assigned before the case, so every path drives
  // state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (accept) begin
          if (digit_bad)                state_next = ERROR;
          else if (idx == DIG_SEC_LSD)  state_next = LOAD;
        end
      end
      LOAD:    state_next = COLLECT;
      ERROR:   state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // The strobes and the ready flag are decoded directly from the state.
  assign o_bcd_ready = (state == COLLECT);
  assign o_load      = (state == LOAD);
  assign o_error     = (state == ERROR);
  assign o_digit_idx = idx;

  // Index counter, staging registers and output registers.
  // NOTE: the data registers are reset as well as the FSM. After reset the
  // loaded time must read 00:00:00, and any partial entry must be discarded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx       <= DIG_HR_MSD;
      msd_hold  <= '0;
      stage_hr  <= '0;
      stage_min <= '0;
      stage_sec <= '0;
      o_hours   <= '0;
      o_minutes <= '0;
      o_seconds <= '0;
    end else if (state == COLLECT) begin
      if (i_abort || (accept && digit_bad)) begin
        idx       <= DIG_HR_MSD;
        msd_hold  <= '0;
        stage_hr  <= '0;
        stage_min <= '0;
        stage_sec <= '0;
      end else if (accept) begin
        idx <= (idx == DIG_SEC_LSD) ? DIG_HR_MSD : idx + 3'd1;
        if (!is_lsd) msd_hold <= i_bcd;
        case (idx)
          DIG_HR_MSD, DIG_HR_LSD:   stage_hr  <= conv_value[HOUR_W-1:0];
          DIG_MIN_MSD, DIG_MIN_LSD: stage_min <= conv_value[MINSEC_W-1:0];
          DIG_SEC_MSD:              stage_sec <= conv_value[MINSEC_W-1:0];
          DIG_SEC_LSD: begin
            // The last digit goes straight to the outputs on the edge that enters LOAD.
            o_hours   <= stage_hr;
            o_minutes <= stage_min;
            o_seconds <= conv_value[MINSEC_W-1:0];
            stage_hr  <= '0;
            stage_min <= '0;
            stage_sec <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
